demux16x8_stream: RTL and testbench

//  Registered 1-to-16 demultiplexer for 8-bit bus traffic; the write-side counterpart of the 16x8 read mux.

---
 rtl/demux16x8_stream_pkg.sv | 24 ++
 rtl/demux16x8_stream_if.sv | 28 ++
 rtl/demux16x8_stream_dec4to16.sv | 15 +
 rtl/demux16x8_stream.sv | 109 ++++++++++
 tb/tb_demux16x8_stream.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/demux16x8_stream_pkg.sv
// Shared constants, FSM state encoding and destination-mask helper for demux16x8_stream.
package demux16x8_stream_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned SEL_W      = 4;
    localparam int unsigned MAX_DEST   = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HEAD  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    // Bit k set for every implemented destination k < n.
    function automatic logic [MAX_DEST-1:0] dest_mask(input int unsigned n);
        logic [MAX_DEST-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < MAX_DEST; k++) begin
            if (k < n) m[k] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/demux16x8_stream_if.sv
// Stream bus of demux16x8_stream: one valid/ready source side, 16 valid/ready destinations.
interface demux16x8_stream_if
    import demux16x8_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [SEL_W-1:0]    in_sel;
    logic [MAX_DEST-1:0] out_valid;
    logic [MAX_DEST-1:0] out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                err_sel;
    logic                busy;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, err_sel, busy
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, err_sel, busy
    );

endinterface

// File: rtl/demux16x8_stream_dec4to16.sv
// Combinational 4-bit select to one-hot decoder with enable.
module demux16x8_stream_dec4to16
    import demux16x8_stream_pkg::*;
(
    input  logic [SEL_W-1:0]    i_sel,
    input  logic                i_en,
    output logic [MAX_DEST-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) o_onehot[i_sel] = 1'b1;
    end

endmodule

// File: rtl/demux16x8_stream.sv
// Registered 1-to-N_DEST stream demultiplexer: head + skid buffer, strict FIFO order,
// illegal destinations accepted, dropped and flagged on err_sel.
module demux16x8_stream
    import demux16x8_stream_pkg::*;
#(
    parameter int unsigned N_DEST = MAX_DEST,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    demux16x8_stream_if.slave bus
);

    localparam int unsigned         SEL_W1    = SEL_W + 1;
    localparam logic [SEL_W:0]      N_DEST_W  = SEL_W1'(N_DEST);
    localparam logic [MAX_DEST-1:0] DEST_MASK = dest_mask(N_DEST);

    state_e              r_state, w_state_next;
    logic                r_in_ready;
    logic                r_err_sel;
    logic [DATA_W-1:0]   r_head_data, w_head_data_next;
    logic [SEL_W-1:0]    r_head_sel, w_head_sel_next;
    logic [DATA_W-1:0]   r_skid_data, w_skid_data_next;
    logic [SEL_W-1:0]    r_skid_sel, w_skid_sel_next;

    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_legal;
    logic [MAX_DEST-1:0] w_onehot;
    logic [MAX_DEST-1:0] w_out_valid;

    demux16x8_stream_dec4to16 u_dec (
        .i_sel    (r_head_sel),
        .i_en     (r_state != ST_EMPTY),
        .o_onehot (w_onehot)
    );

    assign w_out_valid = w_onehot & DEST_MASK;
    assign w_in_xfer   = bus.in_valid & r_in_ready;
    assign w_out_xfer  = |(w_out_valid & bus.out_ready);
    assign w_legal     = {1'b0, bus.in_sel} < N_DEST_W;

    always_comb begin
        w_state_next     = r_state;
        w_head_data_next = r_head_data;
        w_head_sel_next  = r_head_sel;
        w_skid_data_next = r_skid_data;
        w_skid_sel_next  = r_skid_sel;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer && w_legal) begin
                    w_state_next     = ST_HEAD;
                    w_head_data_next = bus.in_data;
                    w_head_sel_next  = bus.in_sel;
                end
            end
            ST_HEAD: begin
                if (w_in_xfer && w_legal) begin
                    if (w_out_xfer) begin
                        w_head_data_next = bus.in_data;
                        w_head_sel_next  = bus.in_sel;
                    end else begin
                        w_state_next     = ST_FULL;
                        w_skid_data_next = bus.in_data;
                        w_skid_sel_next  = bus.in_sel;
                    end
                end else if (w_out_xfer) begin
                    // Also covers a dropped illegal word arriving while the head drains.
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_xfer) begin
                    w_state_next     = ST_HEAD;
                    w_head_data_next = r_skid_data;
                    w_head_sel_next  = r_skid_sel;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_err_sel   <= 1'b0;
            r_head_data <= '0;
            r_head_sel  <= '0;
            r_skid_data <= '0;
            r_skid_sel  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next != ST_FULL);
            r_err_sel   <= w_in_xfer & ~w_legal;
            r_head_data <= w_head_data_next;
            r_head_sel  <= w_head_sel_next;
            r_skid_data <= w_skid_data_next;
            r_skid_sel  <= w_skid_sel_next;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_head_data;
    assign bus.err_sel   = r_err_sel;
    assign bus.busy      = (r_state != ST_EMPTY);

endmodule

// File: tb/tb_demux16x8_stream.sv
// Directed bench for demux16x8_stream: a 16-destination instance and a 12-destination instance.
module tb_demux16x8_stream;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    demux16x8_stream_if #(.DATA_W(8)) a_if ();
    demux16x8_stream_if #(.DATA_W(8)) b_if ();

    demux16x8_stream #(.N_DEST(16), .DATA_W(8)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    demux16x8_stream #(.N_DEST(12), .DATA_W(8)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [7:0] d, input logic [3:0] s);
        a_if.in_valid = v;
        a_if.in_data  = d;
        a_if.in_sel   = s;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] d, input logic [3:0] s);
        b_if.in_valid = v;
        b_if.in_data  = d;
        b_if.in_sel   = s;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        drive_a(1'b0, 8'h00, 4'h0);
        drive_b(1'b0, 8'h00, 4'h0);
        a_if.out_ready = '0;
        b_if.out_ready = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 32'(a_if.in_ready), 32'd1);
        chk("rst_out_valid", 32'(a_if.out_valid), 32'h0);
        chk("rst_out_data", 32'(a_if.out_data), 32'h0);
        chk("rst_busy", 32'(a_if.busy), 32'd0);
        chk("rst_err", 32'(a_if.err_sel), 32'd0);
        #9 rst_n = 1'b1;

        // 1: single word to destination 3
        drive_a(1'b1, 8'hA5, 4'd3);
        a_if.out_ready = 16'hFFFF;
        tick();
        chk("t1_out_valid", 32'(a_if.out_valid), 32'h0008);
        chk("t1_out_data", 32'(a_if.out_data), 32'hA5);
        chk("t1_busy", 32'(a_if.busy), 32'd1);
        drive_a(1'b0, 8'h00, 4'd0);
        tick();
        chk("t1_drained_valid", 32'(a_if.out_valid), 32'h0);
        chk("t1_drained_busy", 32'(a_if.busy), 32'd0);
        chk("t1_data_hold", 32'(a_if.out_data), 32'hA5);

        // 2: back-to-back stream over all destinations
        for (int i = 0; i < 16; i++) begin
            drive_a(1'b1, 8'(i * 17), 4'(i));
            tick();
            chk("t2_out_valid", 32'(a_if.out_valid), 32'(16'(1) << i));
            chk("t2_out_data", 32'(a_if.out_data), 32'(i * 17));
            chk("t2_in_ready", 32'(a_if.in_ready), 32'd1);
        end
        drive_a(1'b0, 8'h00, 4'd0);
        tick();
        chk("t2_busy_end", 32'(a_if.busy), 32'd0);

        // 3: backpressure fills head and skid, third word held at source
        a_if.out_ready = '0;
        drive_a(1'b1, 8'h11, 4'd1);
        tick();
        chk("t3_rdy_after1", 32'(a_if.in_ready), 32'd1);
        chk("t3_valid_after1", 32'(a_if.out_valid), 32'h0002);
        drive_a(1'b1, 8'h22, 4'd2);
        tick();
        chk("t3_rdy_after2", 32'(a_if.in_ready), 32'd0);
        chk("t3_data_after2", 32'(a_if.out_data), 32'h11);
        drive_a(1'b1, 8'h33, 4'd4);
        tick();
        chk("t3_rdy_held", 32'(a_if.in_ready), 32'd0);
        chk("t3_valid_held", 32'(a_if.out_valid), 32'h0002);
        a_if.out_ready = 16'h0002;
        tick();
        chk("t3_valid_w2", 32'(a_if.out_valid), 32'h0004);
        chk("t3_data_w2", 32'(a_if.out_data), 32'h22);
        chk("t3_rdy_w2", 32'(a_if.in_ready), 32'd1);
        a_if.out_ready = 16'h0004;
        tick();
        chk("t3_valid_w3", 32'(a_if.out_valid), 32'h0010);
        chk("t3_data_w3", 32'(a_if.out_data), 32'h33);
        drive_a(1'b0, 8'h00, 4'd0);
        a_if.out_ready = 16'h0010;
        tick();
        chk("t3_busy_end", 32'(a_if.busy), 32'd0);

        // 6: only the pending destination's ready matters
        a_if.out_ready = '0;
        drive_a(1'b1, 8'h5A, 4'd5);
        tick();
        drive_a(1'b0, 8'h00, 4'd0);
        a_if.out_ready = 16'h0040;
        tick();
        chk("t6_wrong_ready_valid", 32'(a_if.out_valid), 32'h0020);
        chk("t6_wrong_ready_busy", 32'(a_if.busy), 32'd1);
        a_if.out_ready = 16'h0020;
        tick();
        chk("t6_xfer_valid", 32'(a_if.out_valid), 32'h0);
        chk("t6_xfer_busy", 32'(a_if.busy), 32'd0);

        // 4: illegal destinations on the 12-destination instance
        b_if.out_ready = 16'hFFFF;
        drive_b(1'b1, 8'h7F, 4'd13);
        tick();
        chk("t4_err_pulse", 32'(b_if.err_sel), 32'd1);
        chk("t4_valid", 32'(b_if.out_valid), 32'h0);
        chk("t4_busy", 32'(b_if.busy), 32'd0);
        chk("t4_in_ready", 32'(b_if.in_ready), 32'd1);
        drive_b(1'b0, 8'h00, 4'd0);
        tick();
        chk("t4_err_clear", 32'(b_if.err_sel), 32'd0);
        drive_b(1'b1, 8'h12, 4'd2);
        tick();
        chk("t4_legal_valid", 32'(b_if.out_valid), 32'h0004);
        drive_b(1'b1, 8'hEE, 4'd14);
        tick();
        chk("t4_drain_err", 32'(b_if.err_sel), 32'd1);
        chk("t4_drain_valid", 32'(b_if.out_valid), 32'h0);
        chk("t4_drain_busy", 32'(b_if.busy), 32'd0);
        b_if.out_ready = '0;
        drive_b(1'b1, 8'h11, 4'd1);
        tick();
        drive_b(1'b1, 8'hFF, 4'd15);
        tick();
        chk("t4_mid_err", 32'(b_if.err_sel), 32'd1);
        chk("t4_mid_rdy", 32'(b_if.in_ready), 32'd1);
        chk("t4_mid_valid", 32'(b_if.out_valid), 32'h0002);
        drive_b(1'b1, 8'h33, 4'd3);
        tick();
        chk("t4_full_err", 32'(b_if.err_sel), 32'd0);
        chk("t4_full_rdy", 32'(b_if.in_ready), 32'd0);
        drive_b(1'b0, 8'h00, 4'd0);
        b_if.out_ready = 16'hFFFF;
        tick();
        chk("t4_order_valid", 32'(b_if.out_valid), 32'h0008);
        chk("t4_order_data", 32'(b_if.out_data), 32'h33);
        tick();
        chk("t4_order_busy", 32'(b_if.busy), 32'd0);

        // 5: asynchronous reset while FULL
        a_if.out_ready = '0;
        drive_a(1'b1, 8'h77, 4'd7);
        tick();
        drive_a(1'b1, 8'h88, 4'd8);
        tick();
        chk("t5_full", 32'(a_if.in_ready), 32'd0);
        drive_a(1'b0, 8'h00, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_rdy", 32'(a_if.in_ready), 32'd1);
        chk("t5_rst_valid", 32'(a_if.out_valid), 32'h0);
        chk("t5_rst_data", 32'(a_if.out_data), 32'h0);
        chk("t5_rst_busy", 32'(a_if.busy), 32'd0);
        #3 rst_n = 1'b1;
        a_if.out_ready = 16'hFFFF;
        tick();
        chk("t5_post_valid", 32'(a_if.out_valid), 32'h0);
        chk("t5_post_rdy", 32'(a_if.in_ready), 32'd1);
        tick();
        chk("t5_post_busy", 32'(a_if.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
